// File: rtl/contador_sched_if.sv
// Requester and counter-pin bundle for contador_sched.
// The scheduler uses the slave modport; the host/counter side uses master.
interface contador_sched_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EVT_W = 8
);
  logic             REQ_A;
  logic             REQ_B;
  logic [1:0]       MODO_A;
  logic [1:0]       MODO_B;
  logic [WIDTH-1:0] D_A;
  logic [WIDTH-1:0] D_B;
  logic [EVT_W-1:0] EVT_A;
  logic [EVT_W-1:0] EVT_B;
  logic             GNT_A;
  logic             GNT_B;
  logic             DONE_A;
  logic             DONE_B;
  logic [WIDTH-1:0] RESULT;
  logic             RESULT_VALID;
  logic             ERR;
  logic             CNT_ENABLE;
  logic [1:0]       CNT_MODO;
  logic [WIDTH-1:0] CNT_D;
  logic             CNT_RCO;
  logic [WIDTH-1:0] CNT_Q;

  modport slave (
    input  REQ_A, REQ_B, MODO_A, MODO_B, D_A, D_B, EVT_A, EVT_B, CNT_RCO, CNT_Q,
    output GNT_A, GNT_B, DONE_A, DONE_B, RESULT, RESULT_VALID, ERR,
           CNT_ENABLE, CNT_MODO, CNT_D
  );

  modport master (
    output REQ_A, REQ_B, MODO_A, MODO_B, D_A, D_B, EVT_A, EVT_B, CNT_RCO, CNT_Q,
    input  GNT_A, GNT_B, DONE_A, DONE_B, RESULT, RESULT_VALID, ERR,
           CNT_ENABLE, CNT_MODO, CNT_D
  );
endinterface

// File: rtl/contador_sched.sv
// Round-robin scheduler sharing one 4-mode counter between requesters A and B.
// Optional RUN watchdog enabled by defining CONTADOR_SCHED_WATCHDOG_EN.
module contador_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned EVT_W   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              RESET,
  contador_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_RUN,
    S_CAPTURE
  } state_e;

  localparam logic       OWN_A     = 1'b0;
  localparam logic       OWN_B     = 1'b1;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] dlat_q, dlat_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic             rv_q, rv_d;
  logic             en_q, en_d;
  logic [1:0]       modo_q, modo_d;
  logic [WIDTH-1:0] cnt_d_q, cnt_d_d;

  logic             sel_b;
  logic [1:0]       sel_mode;
  logic [WIDTH-1:0] sel_d;
  logic [EVT_W-1:0] sel_evt;
  logic [EVT_W-1:0] evt_inc;

`ifdef CONTADOR_SCHED_WATCHDOG_EN
  localparam int unsigned RC_W = $clog2(TIMEOUT + 1);
  logic [RC_W-1:0] run_cnt_q, run_cnt_d;
`else
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Tie goes to whoever was not served last; fields follow the owner.
  assign sel_b    = bus.REQ_B && (!bus.REQ_A || (last_q == OWN_A));
  assign sel_mode = (owner_q == OWN_B) ? bus.MODO_B : bus.MODO_A;
  assign sel_d    = (owner_q == OWN_B) ? bus.D_B    : bus.D_A;
  assign sel_evt  = (owner_q == OWN_B) ? bus.EVT_B  : bus.EVT_A;
  assign evt_inc  = evt_cnt_q + EVT_W'(1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    mode_d    = mode_q;
    dlat_d    = dlat_q;
    evt_d     = evt_q;
    evt_cnt_d = evt_cnt_q;
    err_d     = err_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_A || bus.REQ_B) begin
          owner_d = sel_b;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        mode_d    = sel_mode;
        dlat_d    = sel_d;
        evt_d     = sel_evt;
        err_d     = 1'b0;
        evt_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        state_d = ((mode_q == MODE_LOAD) || (evt_q == '0)) ? S_CAPTURE : S_RUN;
      end
      S_RUN: begin
        if (bus.CNT_RCO) begin
          evt_cnt_d = evt_inc;
          if (evt_inc == evt_q) state_d = S_CAPTURE;
        end
`ifdef CONTADOR_SCHED_WATCHDOG_EN
        // Target met in the same cycle wins over the timeout.
        if ((state_d == S_RUN) && (run_cnt_q == RC_W'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = S_CAPTURE;
        end
`endif
      end
      S_CAPTURE: begin
        result_d = bus.CNT_Q;
        last_d   = owner_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered and reflect the state being entered.
    gnt_a_d  = (state_d != S_IDLE) && (owner_d == OWN_A);
    gnt_b_d  = (state_d != S_IDLE) && (owner_d == OWN_B);
    done_a_d = (state_d == S_CAPTURE) && (owner_d == OWN_A);
    done_b_d = (state_d == S_CAPTURE) && (owner_d == OWN_B);
    rv_d     = (state_d == S_CAPTURE);
    en_d     = (state_d == S_LOAD) || (state_d == S_RUN);
    modo_d   = (state_d == S_RUN) ? mode_d : MODE_LOAD;
    cnt_d_d  = (state_d == S_LOAD) ? dlat_d : cnt_d_q;
  end

`ifdef CONTADOR_SCHED_WATCHDOG_EN
  assign run_cnt_d = (state_q == S_RUN) ? run_cnt_q + RC_W'(1) : '0;
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_A;
      last_q    <= OWN_B;
      mode_q    <= MODE_LOAD;
      dlat_q    <= '0;
      evt_q     <= '0;
      evt_cnt_q <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      rv_q      <= 1'b0;
      en_q      <= 1'b0;
      modo_q    <= MODE_LOAD;
      cnt_d_q   <= '0;
`ifdef CONTADOR_SCHED_WATCHDOG_EN
      run_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      dlat_q    <= dlat_d;
      evt_q     <= evt_d;
      evt_cnt_q <= evt_cnt_d;
      err_q     <= err_d;
      result_q  <= result_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      rv_q      <= rv_d;
      en_q      <= en_d;
      modo_q    <= modo_d;
      cnt_d_q   <= cnt_d_d;
`ifdef CONTADOR_SCHED_WATCHDOG_EN
      run_cnt_q <= run_cnt_d;
`endif
    end
  end

  assign bus.GNT_A        = gnt_a_q;
  assign bus.GNT_B        = gnt_b_q;
  assign bus.DONE_A       = done_a_q;
  assign bus.DONE_B       = done_b_q;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = rv_q;
  assign bus.ERR          = err_q;
  assign bus.CNT_ENABLE   = en_q;
  assign bus.CNT_MODO     = modo_q;
  assign bus.CNT_D        = cnt_d_q;

endmodule

// File: tb/tb_contador_sched.sv
// Bench for contador_sched: behavioural counter plus job-level reference model.
// Honours CONTADOR_SCHED_WATCHDOG_EN for the timeout scenario.
module tb_contador_sched;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned EVT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  contador_sched_if #(.WIDTH(WIDTH), .EVT_W(EVT_W)) bus ();

  contador_sched #(.WIDTH(WIDTH), .EVT_W(EVT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
  );

  // Counter: 00 up, 01 down, 10 down-by-3, 11 load; RCO flags the wrapping step.
  logic [31:0] cq;
  always_ff @(posedge clk) begin
    if (RESET) cq <= '0;
    else if (bus.CNT_ENABLE) begin
      case (bus.CNT_MODO)
        2'b00:   cq <= cq + 32'd1;
        2'b01:   cq <= cq - 32'd1;
        2'b10:   cq <= cq - 32'd3;
        default: cq <= bus.CNT_D;
      endcase
    end
  end
  assign bus.CNT_Q   = cq;
  assign bus.CNT_RCO = bus.CNT_ENABLE &&
                       (((bus.CNT_MODO == 2'b00) && (cq == 32'hFFFF_FFFF)) ||
                        ((bus.CNT_MODO == 2'b01) && (cq == 32'd0)) ||
                        ((bus.CNT_MODO == 2'b10) && (cq < 32'd3)));

  // Job result: start at D, step until EVT wraps have happened; cyc = RUN cycles.
  function automatic logic [31:0] ref_job(input logic [1:0] m, input logic [31:0] d,
                                          input logic [7:0] e, output int cyc);
    logic [31:0] q;
    int hits;
    q = d; hits = 0; cyc = 0;
    if (m == 2'b11 || e == 8'd0) return d;
    while (hits < int'(e) && cyc < 1000) begin
      case (m)
        2'b00:   begin if (q == 32'hFFFF_FFFF) hits++; q = q + 32'd1; end
        2'b01:   begin if (q == 32'd0) hits++; q = q - 32'd1; end
        default: begin if (q < 32'd3) hits++; q = q - 32'd3; end
      endcase
      cyc++;
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input bit who, input logic [1:0] m, input logic [31:0] d,
                            input logic [7:0] e);
    if (who) begin bus.MODO_B = m; bus.D_B = d; bus.EVT_B = e; end
    else     begin bus.MODO_A = m; bus.D_A = d; bus.EVT_A = e; end
  endtask

  task automatic set_req(input bit who, input logic v);
    if (who) bus.REQ_B = v; else bus.REQ_A = v;
  endtask

  // Single-requester job; drop_after > 0 drops REQ and scrambles fields at that cycle.
  task automatic run_job(input string tag, input bit who, input logic [1:0] m,
                         input logic [31:0] d, input logic [7:0] e, input int drop_after);
    int c, k;
    logic [31:0] exp_q;
    bit seen, both;
    exp_q = ref_job(m, d, e, c);
    set_fields(who, m, d, e);
    set_req(who, 1'b1);
    k = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk); k++;
      seen = who ? bus.GNT_B : bus.GNT_A;
    end
    chk({tag, " gnt_latency"}, 64'(k), 64'd1);
    k = 0; seen = 0; both = 0;
    for (int i = 0; i < c + 40 && !seen; i++) begin
      @(negedge clk); k++;
      if (k == drop_after) begin
        set_req(who, 1'b0);
        set_fields(who, 2'b11, $urandom, 8'($urandom));
      end
      if (bus.GNT_A && bus.GNT_B) both = 1;
      seen = who ? bus.DONE_B : bus.DONE_A;
    end
    chk({tag, " done_latency"}, 64'(k), 64'(c + 2));
    chk({tag, " both_gnt"}, 64'(both), 64'd0);
    chk({tag, " result_valid"}, 64'(bus.RESULT_VALID), 64'd1);
    chk({tag, " other_done"}, 64'(who ? bus.DONE_A : bus.DONE_B), 64'd0);
    chk({tag, " err"}, 64'(bus.ERR), 64'd0);
    set_req(who, 1'b0);
    @(negedge clk);
    chk({tag, " result"}, 64'(bus.RESULT), 64'(exp_q));
    chk({tag, " gnt_drop"}, 64'(who ? bus.GNT_B : bus.GNT_A), 64'd0);
    chk({tag, " rv_pulse"}, 64'(bus.RESULT_VALID), 64'd0);
  endtask

  initial begin
    int c, k;
    bit seen, both, exp_b;
    logic [1:0]  m;
    logic [31:0] d, exp_q;

    RESET = 1'b1;
    bus.REQ_A = 0; bus.REQ_B = 0;
    set_fields(0, 2'b00, 32'd0, 8'd0);
    set_fields(1, 2'b00, 32'd0, 8'd0);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst gnt_a", 64'(bus.GNT_A), 64'd0);
    chk("rst gnt_b", 64'(bus.GNT_B), 64'd0);
    chk("rst done", 64'({bus.DONE_A, bus.DONE_B}), 64'd0);
    chk("rst rv", 64'(bus.RESULT_VALID), 64'd0);
    chk("rst err", 64'(bus.ERR), 64'd0);
    chk("rst en", 64'(bus.CNT_ENABLE), 64'd0);
    chk("rst modo", 64'(bus.CNT_MODO), 64'd3);
    chk("rst cnt_d", 64'(bus.CNT_D), 64'd0);
    chk("rst result", 64'(bus.RESULT), 64'd0);
    RESET = 1'b0;
    @(negedge clk);

    run_job("a_wrap", 0, 2'b00, 32'hFFFF_FFFE, 8'd1, 0);
    run_job("b_load", 1, 2'b11, 32'h1234_5678, 8'd5, 0);
    run_job("a_drop", 0, 2'b01, 32'd2, 8'd1, 3);

    // Randomized single-requester jobs near the wrap points
    for (int j = 0; j < 16; j++) begin
      m = 2'($urandom_range(0, 3));
      case (m)
        2'b00:   d = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        2'b01:   d = 32'($urandom_range(0, 4));
        2'b10:   d = 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      run_job("rand", 1'($urandom_range(0, 1)), m, d, 8'($urandom_range(0, 1)), 0);
      @(negedge clk);
    end

    // Contention from reset: expect A, B, A
    RESET = 1'b1;
    set_fields(0, 2'b00, 32'hFFFF_FFFF, 8'd1);
    set_fields(1, 2'b01, 32'd1, 8'd1);
    bus.REQ_A = 1; bus.REQ_B = 1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_b = (j == 1);
      exp_q = exp_b ? ref_job(2'b01, 32'd1, 8'd1, c) : ref_job(2'b00, 32'hFFFF_FFFF, 8'd1, c);
      k = 0; seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge clk); k++;
        seen = bus.GNT_A || bus.GNT_B;
      end
      chk("rr gnt_latency", 64'(k), 64'd1);
      chk("rr owner_b", 64'(bus.GNT_B), 64'(exp_b));
      k = 0; seen = 0; both = (bus.GNT_A && bus.GNT_B);
      for (int i = 0; i < c + 40 && !seen; i++) begin
        @(negedge clk); k++;
        if (bus.GNT_A && bus.GNT_B) both = 1;
        seen = exp_b ? bus.DONE_B : bus.DONE_A;
      end
      chk("rr done_latency", 64'(k), 64'(c + 2));
      chk("rr both_gnt", 64'(both), 64'd0);
      if (j == 2) begin bus.REQ_A = 0; bus.REQ_B = 0; end
      @(negedge clk);
      chk("rr result", 64'(bus.RESULT), 64'(exp_q));
    end

    // Reset during RUN aborts without DONE
    set_fields(0, 2'b00, 32'd0, 8'd1);
    bus.REQ_A = 1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.GNT_A; end
    chk("rstrun gnt", 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    chk("rstrun in_run", 64'({bus.CNT_ENABLE, bus.CNT_MODO}), 64'b100);
    RESET = 1'b1;
    @(negedge clk);
    bus.REQ_A = 0;
    chk("rstrun gnt_a", 64'(bus.GNT_A), 64'd0);
    chk("rstrun en", 64'(bus.CNT_ENABLE), 64'd0);
    chk("rstrun modo", 64'(bus.CNT_MODO), 64'd3);
    chk("rstrun done", 64'({bus.DONE_A, bus.RESULT_VALID}), 64'd0);
    RESET = 1'b0;
    @(negedge clk);

    // Second wrap never comes within TIMEOUT RUN cycles
    set_fields(0, 2'b00, 32'd0, 8'd2);
    bus.REQ_A = 1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin @(negedge clk); seen = bus.GNT_A; end
    chk("wd gnt", 64'(seen), 64'd1);
`ifdef CONTADOR_SCHED_WATCHDOG_EN
    k = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); k++; seen = bus.DONE_A; end
    chk("wd done_latency", 64'(k), 64'(TIMEOUT + 2));
    chk("wd err", 64'(bus.ERR), 64'd1);
    chk("wd rv", 64'(bus.RESULT_VALID), 64'd1);
    bus.REQ_A = 0;
    @(negedge clk);
    chk("wd result", 64'(bus.RESULT), 64'(TIMEOUT));
    chk("wd err_hold", 64'(bus.ERR), 64'd1);
`else
    seen = 0;
    repeat (TIMEOUT + 2) begin @(negedge clk); if (bus.DONE_A) seen = 1; end
    chk("wd no_done", 64'(seen), 64'd0);
    chk("wd still_run", 64'({bus.GNT_A, bus.CNT_ENABLE, bus.CNT_MODO}), 64'b1100);
    chk("wd err", 64'(bus.ERR), 64'd0);
    RESET = 1'b1;
    @(negedge clk);
    bus.REQ_A = 0;
    chk("wd rst_gnt", 64'(bus.GNT_A), 64'd0);
    RESET = 1'b0;
    @(negedge clk);
`endif
    run_job("after_wd", 0, 2'b10, 32'd1, 8'd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
